// File: rtl/adpcm_main_pkg.sv
// Shared types and helpers for the ADPCM filter-path MAC accumulator.
package adpcm_main_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } mac_state_e;

   localparam int MAX_W = 128;

   function automatic int acc_width(input int in_width, input int num_taps);
      return in_width + $clog2(num_taps);
   endfunction

   // Clamp a wide signed value into the signed range of out_width bits.
   function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] value,
                                                         input int out_width);
      logic signed [MAX_W-1:0] max_v;
      logic signed [MAX_W-1:0] min_v;
      max_v = ~({MAX_W{1'b1}} << (out_width - 1));
      min_v = ~max_v;
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/adpcm_main_mac_acc_if.sv
// Product-in / result-out valid-ready streams of the ADPCM MAC accumulator.
interface adpcm_main_mac_acc_if #(
   parameter int IN_WIDTH  = 40,
   parameter int OUT_WIDTH = 32
);
   logic                        in_valid;
   logic signed [IN_WIDTH-1:0]  in_data;
   logic                        in_ready;
   logic                        out_valid;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic                        out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/adpcm_main_mac_acc.sv
// Filter-tap MAC: sums NUM_TAPS signed products per frame, emits (sum >>> SHIFT) in OUT_WIDTH bits.
// Define ADPCM_MAC_SAT_EN to saturate the result instead of wrapping it.
module adpcm_main_mac_acc
   import adpcm_main_pkg::*;
#(
   parameter int IN_WIDTH  = 40,
   parameter int NUM_TAPS  = 6,
   parameter int SHIFT     = 14,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   adpcm_main_mac_acc_if.slave  bus
);

   localparam int ACC_W = acc_width(IN_WIDTH, NUM_TAPS);
   localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   mac_state_e                  state_r;
   logic signed [ACC_W-1:0]     acc_r;
   logic [CNT_W-1:0]            cnt_r;
   logic signed [OUT_WIDTH-1:0] out_data_r;

   logic                        in_ready_s;
   logic                        accept_s;
   logic                        cont_s;
   logic                        last_s;
   logic signed [ACC_W-1:0]     in_ext_s;
   logic signed [ACC_W-1:0]     sum_s;
   logic signed [ACC_W-1:0]     shifted_s;
   logic signed [OUT_WIDTH-1:0] result_s;

   // Handshake decode and next-sum / reduced-result datapath.
   always_comb begin
      in_ready_s = ce & ((state_r != HOLD) | bus.out_ready);
      accept_s   = in_ready_s & bus.in_valid;
      cont_s     = (state_r == ACC);
      in_ext_s   = ACC_W'(bus.in_data);
      // A frame started from IDLE or HOLD has no prior partial sum.
      if (cont_s) begin
         sum_s = acc_r + in_ext_s;
      end else begin
         sum_s = in_ext_s;
      end
      last_s    = (NUM_TAPS == 1) | (cont_s & (cnt_r == LAST_CNT));
      shifted_s = sum_s >>> SHIFT;
`ifdef ADPCM_MAC_SAT_EN
      result_s  = OUT_WIDTH'(sat_trunc(MAX_W'(shifted_s), OUT_WIDTH));
`else
      result_s  = OUT_WIDTH'(shifted_s);
`endif
   end

   // Frame state, accumulator, tap counter and held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         acc_r      <= '0;
         cnt_r      <= '0;
         out_data_r <= '0;
      end else if (ce) begin
         // In HOLD an accept implies out_ready, so it also retires the held result.
         if (accept_s) begin
            acc_r <= sum_s;
            if (last_s) begin
               state_r    <= HOLD;
               cnt_r      <= '0;
               out_data_r <= result_s;
            end else begin
               state_r <= ACC;
               cnt_r   <= cont_s ? (cnt_r + CNT_ONE) : CNT_ONE;
            end
         end else if ((state_r == HOLD) && bus.out_ready) begin
            state_r <= IDLE;
         end else begin
            state_r <= state_r;
         end
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_r == HOLD);
   assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_adpcm_main_mac_acc.sv
// Directed self-checking bench for adpcm_main_mac_acc (32-bit and 16-bit result builds).
module tb_adpcm_main_mac_acc;
   import adpcm_main_pkg::*;

   localparam logic signed [15:0] EXP_POS16 =
`ifdef ADPCM_MAC_SAT_EN
      16'sd32767;
`else
      16'sd0;
`endif
   localparam logic signed [15:0] EXP_NEG16 =
`ifdef ADPCM_MAC_SAT_EN
      -16'sd32768;
`else
      16'sd0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic ce;
   int   total = 0;
   int   bad   = 0;

   adpcm_main_mac_acc_if #(.IN_WIDTH(40), .OUT_WIDTH(32)) bus ();
   adpcm_main_mac_acc_if #(.IN_WIDTH(40), .OUT_WIDTH(16)) bus16 ();

   adpcm_main_mac_acc #(.IN_WIDTH(40), .NUM_TAPS(6), .SHIFT(14), .OUT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .ce(ce), .bus(bus.slave));
   adpcm_main_mac_acc #(.IN_WIDTH(40), .NUM_TAPS(6), .SHIFT(14), .OUT_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .ce(ce), .bus(bus16.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [39:0] v);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      tick();
   endtask

   task automatic frame6(input logic signed [39:0] v0, v1, v2, v3, v4, v5);
      send(v0); send(v1); send(v2); send(v3); send(v4); send(v5);
      bus.in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ce = 1'b1;
      bus.in_valid = 1'b0;   bus.in_data = '0;   bus.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out_data !== 32'sd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", bus.out_data); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus16.out_data !== 16'sd0) begin bad++; $display("FAIL reset_data16 got=%0d exp=0", bus16.out_data); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 5; i++) send(40'sd16384);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", bus.out_valid); end
      send(40'sd16384);
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
      total++; if (bus.out_data !== 32'sd6) begin bad++; $display("FAIL basic_data got=%0d exp=6", bus.out_data); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_retire got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_signed();
      logic signed [39:0] vec [3][6];
      logic signed [31:0] exp_v [3];
      vec[0] = '{-40'sd16384, -40'sd16384, -40'sd16384, -40'sd16384, -40'sd16384, -40'sd16384};
      vec[1] = '{40'sd5, -40'sd6, 40'sd0, 40'sd0, 40'sd0, 40'sd0};
      vec[2] = '{40'sd100000, 40'sd200000, -40'sd50000, 40'sd16384, 40'sd0, 40'sd1};
      exp_v  = '{-32'sd6, -32'sd1, 32'sd16};
      for (int f = 0; f < 3; f++) begin
         frame6(vec[f][0], vec[f][1], vec[f][2], vec[f][3], vec[f][4], vec[f][5]);
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL signed_valid[%0d] got=%b exp=1", f, bus.out_valid); end
         total++; if (bus.out_data !== exp_v[f]) begin bad++; $display("FAIL signed_data[%0d] got=%0d exp=%0d", f, bus.out_data, exp_v[f]); end
         tick();
      end
   endtask

   task automatic test_reduce16();
      logic signed [39:0] v [2];
      logic signed [15:0] exp_v [2];
      v     = '{40'sd1073741824, -40'sd1073741824};
      exp_v = '{EXP_POS16, EXP_NEG16};
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 6; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_data  = v[f];
            tick();
         end
         bus16.in_valid = 1'b0;
         #1;
         total++; if (bus16.out_valid !== 1'b1) begin bad++; $display("FAIL reduce16_valid[%0d] got=%b exp=1", f, bus16.out_valid); end
         total++; if (bus16.out_data !== exp_v[f]) begin bad++; $display("FAIL reduce16_data[%0d] got=%0d exp=%0d", f, bus16.out_data, exp_v[f]); end
         tick();
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 3; i++) send(40'sd16384);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", bus.out_valid); end
      frame6(40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384);
      total++; if (bus.out_data !== 32'sd6) begin bad++; $display("FAIL midreset_data got=%0d exp=6", bus.out_data); end
      tick();
   endtask

   task automatic test_stall();
      bus.out_ready = 1'b0;
      frame6(40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384, 40'sd16384);
      total++; if (bus.out_data !== 32'sd6) begin bad++; $display("FAIL hold_first got=%0d exp=6", bus.out_data); end
      bus.in_valid = 1'b1;
      bus.in_data  = 40'sd999;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
         tick();
         total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'sd6) begin
            bad++; $display("FAIL hold_stable[%0d] got=%b/%0d exp=1/6", i, bus.out_valid, bus.out_data); end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_retire got=%b exp=0", bus.out_valid); end
      for (int i = 0; i < 3; i++) send(40'sd16384);
      ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ce_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
         tick();
      end
      ce = 1'b1;
      for (int i = 0; i < 3; i++) send(40'sd16384);
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'sd6) begin
         bad++; $display("FAIL ce_sum got=%b/%0d exp=1/6", bus.out_valid, bus.out_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 18; i++) begin
         logic signed [39:0] v;
         logic               exp_valid;
         v = 40'sd16384 * (i / 6 + 1);
         exp_valid = ((i % 6) == 5);
         send(v);
         total++; if (bus.out_valid !== exp_valid) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, bus.out_valid, exp_valid); end
         total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
         if (exp_valid) begin
            total++; if (bus.out_data !== 32'(6 * (i / 6 + 1))) begin
               bad++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, bus.out_data, 6 * (i / 6 + 1)); end
         end
      end
      bus.in_valid = 1'b0;
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_reduce16();
      test_reset_midframe();
      test_stall();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
